// File: rtl/lcd_bus_responder.sv
// Panel-side HD44780-compatible responder for the 8-bit LCD bus: captures E-strobed
// writes, runs the wakeup/config sequence, enforces busy times and keeps a 2x16 shadow.
module lcd_bus_responder #(
  parameter int CMD_CYCLES  = 4,
  parameter int CLR_CYCLES  = 164,
  parameter int WAKE_CYCLES = 410
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       two_line,
  output logic       init_done,
  output logic       busy_flag,
  output logic       upd,
  output logic       err_busy,
  output logic       err_seq,
  output logic       err_addr,
  output logic [2:0] dbg_state
);

  // Bus protocol: the host strobes E with no ready/ack path; a write is an E falling
  // edge and cannot be stalled. busy_flag is advisory; writes arriving while it is
  // high are dropped and flagged in err_busy.

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_WAKE1  = 3'd1,
    ST_WAKE2  = 3'd2,
    ST_CONFIG = 3'd3,
    ST_READY  = 3'd4
  } state_t;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic       e;
    logic [7:0] data;
  } bus_t;

  bus_t        s1, s2, s3;
  state_t      state, state_d;
  logic [15:0] busy_cnt, busy_d;
  logic [6:0]  cursor_d, cur_step;
  logic        disp_on_d, two_line_d, inc, inc_d;
  logic        err_busy_d, err_seq_d, err_addr_d, upd_d;
  logic        wr_en, clr_all, wr_evt, addr_legal;
  logic [4:0]  wr_idx;
  logic [7:0]  shadow [32];

  // s3 holds the last sample taken while E was high
  assign wr_evt     = !s2.e && s3.e && !s3.rw;
  assign busy_flag  = (busy_cnt != 16'd0);
  assign init_done  = (state == ST_READY);
  assign dbg_state  = state;
  assign wr_idx     = {cursor_addr[6], cursor_addr[3:0]};
  assign addr_legal = (s3.data[6:0] <= 7'h27) ||
                      ((s3.data[6:0] >= 7'h40) && (s3.data[6:0] <= 7'h67));

  always_comb begin
    if (inc) begin
      if (cursor_addr == 7'h27)      cur_step = 7'h40;
      else if (cursor_addr == 7'h67) cur_step = 7'h00;
      else                           cur_step = cursor_addr + 7'd1;
    end else begin
      if (cursor_addr == 7'h00)      cur_step = 7'h67;
      else if (cursor_addr == 7'h40) cur_step = 7'h27;
      else                           cur_step = cursor_addr - 7'd1;
    end
  end

  always_comb begin
    state_d    = state;
    busy_d     = busy_flag ? busy_cnt - 16'd1 : 16'd0;
    cursor_d   = cursor_addr;
    disp_on_d  = disp_on;
    two_line_d = two_line;
    inc_d      = inc;
    err_busy_d = err_busy;
    err_seq_d  = err_seq;
    err_addr_d = err_addr;
    upd_d      = 1'b0;
    wr_en      = 1'b0;
    clr_all    = 1'b0;
    if (wr_evt) begin
      if (busy_flag) begin
        err_busy_d = 1'b1;
      end else begin
        case (state)
          ST_RESET, ST_WAKE1, ST_WAKE2: begin
            if (!s3.rs && s3.data == 8'h30) begin
              busy_d = (state == ST_RESET) ? 16'(WAKE_CYCLES) : 16'(CMD_CYCLES);
              case (state)
                ST_RESET: state_d = ST_WAKE1;
                ST_WAKE1: state_d = ST_WAKE2;
                default:  state_d = ST_CONFIG;
              endcase
            end else begin
              err_seq_d = 1'b1;
            end
          end
          default: begin
            if (s3.rs) begin
              if (state != ST_READY) begin
                err_seq_d = 1'b1;
              end else begin
                // only the 16 visible columns of each row are shadowed
                if (cursor_addr[5:4] == 2'b00) begin
                  wr_en = 1'b1;
                  upd_d = 1'b1;
                end
                cursor_d = cur_step;
                busy_d   = 16'(CMD_CYCLES);
              end
            end else begin
              busy_d = 16'(CMD_CYCLES);
              if (s3.data[7]) begin
                if (addr_legal) cursor_d = s3.data[6:0];
                else            err_addr_d = 1'b1;
              end else if (s3.data[6]) begin
                busy_d = 16'(CMD_CYCLES);
              end else if (s3.data[5]) begin
                two_line_d = s3.data[3];
              end else if (s3.data[4]) begin
                busy_d = 16'(CMD_CYCLES);
              end else if (s3.data[3]) begin
                disp_on_d = s3.data[2];
                if (s3.data[2]) state_d = ST_READY;
              end else if (s3.data[2]) begin
                inc_d = s3.data[1];
              end else if (s3.data[1]) begin
                cursor_d = 7'h00;
                busy_d   = 16'(CLR_CYCLES);
              end else if (s3.data[0]) begin
                clr_all  = 1'b1;
                cursor_d = 7'h00;
                inc_d    = 1'b1;
                upd_d    = 1'b1;
                busy_d   = 16'(CLR_CYCLES);
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      state       <= ST_RESET;
      busy_cnt    <= 16'd0;
      cursor_addr <= 7'h00;
      disp_on     <= 1'b0;
      two_line    <= 1'b0;
      inc         <= 1'b1;
      err_busy    <= 1'b0;
      err_seq     <= 1'b0;
      err_addr    <= 1'b0;
      upd         <= 1'b0;
      rd_char     <= 8'h00;
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
    end else begin
      s1          <= {lcd_rs, lcd_rw, lcd_e, lcd_data};
      s2          <= s1;
      s3          <= s2;
      state       <= state_d;
      busy_cnt    <= busy_d;
      cursor_addr <= cursor_d;
      disp_on     <= disp_on_d;
      two_line    <= two_line_d;
      inc         <= inc_d;
      err_busy    <= err_busy_d;
      err_seq     <= err_seq_d;
      err_addr    <= err_addr_d;
      upd         <= upd_d;
      rd_char     <= shadow[rd_addr];
      if (clr_all) begin
        for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
      end else if (wr_en) begin
        shadow[wr_idx] <= s3.data;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: directed test-plan scenarios plus a
// randomized command/data stream checked against a behavioural display model.
module tb_lcd_bus_responder;

  localparam int CMD  = 4;
  localparam int CLR  = 164;
  localparam int WAKE = 410;

  logic       clk, rst_n;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       disp_on, two_line, init_done, busy_flag, upd;
  logic       err_busy, err_seq, err_addr;
  logic [2:0] dbg_state;

  lcd_bus_responder #(.CMD_CYCLES(CMD), .CLR_CYCLES(CLR), .WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
    .cursor_addr(cursor_addr), .disp_on(disp_on), .two_line(two_line),
    .init_done(init_done), .busy_flag(busy_flag), .upd(upd),
    .err_busy(err_busy), .err_seq(err_seq), .err_addr(err_addr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  int upd_seen = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (upd === 1'b1) upd_seen = upd_seen + 1;

  // ---------------- scoreboard / checking ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural display model ----------------
  // phase: 0 before any wakeup, 1..2 after each wakeup, 3 configuring, 4 ready
  int         m_phase;
  int         m_cur;
  bit         m_inc, m_disp, m_two, m_eb, m_es, m_ea;
  logic [7:0] m_sh[32];
  int         m_busy_end;
  int         m_upd = 0;

  function automatic void model_reset();
    m_phase = 0; m_cur = 0; m_inc = 1; m_disp = 0; m_two = 0;
    m_eb = 0; m_es = 0; m_ea = 0; m_busy_end = -1;
    for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
  endfunction

  // x = clock edge at which the event takes effect
  function automatic void model_event(bit rs, bit rw, logic [7:0] d, int x);
    int n, a;
    if (rw) return;
    if (x <= m_busy_end) begin m_eb = 1; return; end
    if (m_phase < 3) begin
      if (!rs && d == 8'h30) begin
        m_busy_end = x + ((m_phase == 0) ? WAKE : CMD);
        m_phase++;
      end else m_es = 1;
      return;
    end
    if (rs) begin
      if (m_phase != 4) begin m_es = 1; return; end
      if (m_cur < 16) begin m_sh[m_cur] = d; m_upd++; end
      else if (m_cur >= 64 && m_cur < 80) begin m_sh[m_cur - 48] = d; m_upd++; end
      if (m_inc) m_cur = (m_cur == 39) ? 64 : (m_cur == 103) ? 0 : m_cur + 1;
      else       m_cur = (m_cur == 0) ? 103 : (m_cur == 64) ? 39 : m_cur - 1;
      m_busy_end = x + CMD;
      return;
    end
    n = CMD;
    if (d >= 128) begin
      a = int'(d) - 128;
      if (a <= 39 || (a >= 64 && a <= 103)) m_cur = a; else m_ea = 1;
    end else if (d >= 64) begin
      n = CMD;
    end else if (d >= 32) begin
      m_two = d[3];
    end else if (d >= 16) begin
      n = CMD;
    end else if (d >= 8) begin
      m_disp = d[2];
      if (d[2]) m_phase = 4;
    end else if (d >= 4) begin
      m_inc = d[1];
    end else if (d >= 2) begin
      m_cur = 0; n = CLR;
    end else if (d == 1) begin
      for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
      m_cur = 0; m_inc = 1; m_upd++; n = CLR;
    end
    m_busy_end = x + n;
  endfunction

  // ---------------- driver tasks ----------------
  // One E pulse (1 cycle high, 1 low) followed by gap further idle cycles.
  task automatic send(input bit rs, input bit rw, input logic [7:0] d, input int gap);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    model_event(rs, rw, d, cyc + 3);
    @(negedge clk);
    lcd_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic read_chk(input int idx);
    rd_addr = 5'(idx);
    @(negedge clk);
    chk($sformatf("rd_char[%0d]", idx), {24'd0, rd_char}, {24'd0, m_sh[idx]});
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".cursor"},   {25'd0, cursor_addr}, 32'(m_cur));
    chk({tag, ".disp_on"},  {31'd0, disp_on},   {31'd0, m_disp});
    chk({tag, ".two_line"}, {31'd0, two_line},  {31'd0, m_two});
    chk({tag, ".init"},     {31'd0, init_done}, {31'd0, (m_phase == 4)});
    chk({tag, ".err_busy"}, {31'd0, err_busy},  {31'd0, m_eb});
    chk({tag, ".err_seq"},  {31'd0, err_seq},   {31'd0, m_es});
    chk({tag, ".err_addr"}, {31'd0, err_addr},  {31'd0, m_ea});
    chk({tag, ".upd_cnt"},  32'(upd_seen),      32'(m_upd));
  endtask

  task automatic check_shadow();
    for (int i = 0; i < 32; i++) read_chk(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".rd_char"}, {24'd0, rd_char}, 32'h00);
    chk({tag, ".cursor"},  {25'd0, cursor_addr}, 32'h00);
    chk({tag, ".flags"},   {24'd0, upd, disp_on, two_line, init_done, busy_flag,
                            err_busy, err_seq, err_addr}, 32'h00);
  endtask

  // count cycles with busy_flag high inside a bounded window after the last pulse
  task automatic measure_busy(input string tag, input int window, input int exp);
    int hi = 0;
    for (int i = 0; i < window; i++) begin
      if (busy_flag === 1'b1) hi++;
      @(negedge clk);
    end
    chk(tag, 32'(hi), 32'(exp));
  endtask

  task automatic do_reset();
    lcd_e = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic driver_init();
    send(0, 0, 8'h30, 505);
    send(0, 0, 8'h30, 15);
    send(0, 0, 8'h30, 12);
    send(0, 0, 8'h38, 12);
    send(0, 0, 8'h08, 12);
    send(0, 0, 8'h01, 202);
    send(0, 0, 8'h06, 12);
    send(0, 0, 8'h0C, 12);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind, gap, base;
    logic [7:0] d;
    bit rs, rw;
    rst_n = 1'b0; lcd_rs = 0; lcd_rw = 0; lcd_e = 0; lcd_data = 0; rd_addr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // data write before init is a sequence error and leaves the shadow alone
    send(1, 0, 8'h41, 12);
    chk("pre_init.err_seq", {31'd0, err_seq}, 32'd1);
    check_state("pre_init");
    read_chk(0);
    do_reset();
    chk("after_reset.err_seq", {31'd0, err_seq}, 32'd0);

    driver_init();
    chk("init.done", {31'd0, init_done}, 32'd1);
    check_state("init");
    check_shadow();

    // positioned write
    base = upd_seen;
    send(0, 0, 8'hC5, 12);
    send(1, 0, 8'h41, 12);
    read_chk(21);
    chk("pos.cursor", {25'd0, cursor_addr}, 32'h46);
    chk("pos.upd_once", 32'(upd_seen - base), 32'd1);

    // row-end wrap outside the visible window
    base = upd_seen;
    send(0, 0, 8'hA7, 12);
    send(1, 0, 8'h58, 12);
    chk("wrap27.no_upd", 32'(upd_seen - base), 32'd0);
    chk("wrap27.cursor", {25'd0, cursor_addr}, 32'h40);
    send(0, 0, 8'hCF, 12);
    send(1, 0, 8'h5A, 12);
    read_chk(31);
    chk("edge4f.cursor", {25'd0, cursor_addr}, 32'h50);
    send(0, 0, 8'h80, 12);
    send(0, 0, 8'h04, 12);
    send(1, 0, 8'h33, 12);
    chk("dec_wrap.cursor", {25'd0, cursor_addr}, 32'h67);
    send(0, 0, 8'h06, 12);

    // illegal DDRAM address
    send(0, 0, 8'h83, 12);
    send(0, 0, 8'hA8, 12);
    chk("bad_addr.err_addr", {31'd0, err_addr}, 32'd1);
    chk("bad_addr.cursor", {25'd0, cursor_addr}, 32'h03);

    // busy durations
    send(0, 0, 8'h14, 0);
    measure_busy("busy_len.cmd", 20, CMD);
    send(0, 0, 8'h02, 0);
    measure_busy("busy_len.home", 200, CLR);

    // busy violation: second fall two cycles after the first
    send(0, 0, 8'h85, 12);
    send(1, 0, 8'h4B, 0);
    send(1, 0, 8'h4C, 12);
    chk("busy_viol.err_busy", {31'd0, err_busy}, 32'd1);
    read_chk(5);
    read_chk(6);
    check_state("busy_viol");

    // randomized command/data stream
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 11);
      rs = 0; rw = 0;
      if (kind <= 4) begin rs = 1; d = 8'($urandom_range(32, 126)); end
      else if (kind <= 6) d = 8'h80 | 8'($urandom_range(0, 127));
      else if (kind == 7) d = 8'h04 | {6'd0, 1'($urandom), 1'b0};
      else if (kind == 8) d = 8'($urandom_range(8, 127));
      else if (kind == 9) begin rw = 1; d = 8'($urandom); end
      else if (kind == 10) d = 8'h0C;
      else d = 8'($urandom_range(1, 3));
      if (d <= 8'h03 && !rs && !rw) gap = 170;
      else gap = ($urandom_range(0, 9) < 2) ? $urandom_range(0, 1) : $urandom_range(4, 8);
      send(rs, rw, d, gap);
      if (gap >= 2) chk($sformatf("rand%0d.cursor", it), {25'd0, cursor_addr}, 32'(m_cur));
    end
    repeat (200) @(negedge clk);
    check_state("rand_end");
    check_shadow();
    for (int i = 0; i < 32; i++) exp_q.push_back(m_sh[i]);

    // reset in the middle of a Clear's busy window
    send(0, 0, 8'h01, 20);
    chk("mid.busy_before", {31'd0, busy_flag}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("post_reset");
    check_shadow();
    driver_init();
    check_state("reinit");
    chk("reinit.init", {31'd0, init_done}, 32'd1);
    check_shadow();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop so the run cannot hang
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Synthesizable HD44780-compatible responder: the panel-side end of the 8-bit parallel LCD bus driven by the team's text LCD driver. It samples RS/RW/E/DB, decodes instructions and character writes, and enforces controller busy times. It also keeps a 2×16 shadow of the visible display readable by other logic (debug UART, VGA mirror, self-check bench). It sits in the same 100 kHz clock domain as the driver.

## Interface
- `CMD_CYCLES`, default 4: busy time after an ordinary instruction or data write (40 µs at 100 kHz).
- `CLR_CYCLES`, default 164: busy time after Clear Display or Return Home.
- `WAKE_CYCLES`, default 410: busy time after the first wakeup (0x30).
- `clk`  in  1  system clock, 100 kHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `lcd_rs`, `lcd_rw`, `lcd_e`  in  1 each  LCD bus controls.
- `lcd_data`  in  8  LCD data bus.
- `rd_addr`  in  5  shadow read index, computed as row×16 + col.
- `rd_char`  out  8  shadow character at `rd_addr`, registered.
- `cursor_addr`  out  7  current DDRAM address counter.
- `disp_on`, `two_line`  out  1 each  decoded display state.
- `init_done`  out  1  wakeup/config sequence completed.
- `busy_flag`  out  1  internal busy counter is non-zero.
- `upd`  out  1  one-cycle pulse when a shadow character changes.
- `err_busy`, `err_seq`, `err_addr`  out  1 each  sticky protocol-error flags.

## Operation
- **Input capture**
  - `lcd_rs`, `lcd_rw`, `lcd_e` and `lcd_data` pass through a 2-flop synchronizer plus one history stage.
  - A write event is the falling edge of the synchronized E (stage2=0, stage3=1).
  - RS, RW and data are taken from stage3, which is the last sample taken with E high.
- **RW=1 events** are ignored: no effect, no busy, no error.
- **Busy handling**
  - An event arriving while `busy_flag`=1 is dropped and sets `err_busy`.
  - Each accepted event loads the busy counter with its class time.
  - The counter decrements to 0 each cycle.
- **Sequence FSM**: RESET → WAKE1 → WAKE2 → CONFIG → READY.
  - RESET, WAKE1, WAKE2: only RS=0 with data 0x30 advances the FSM.
    - The RESET→WAKE1 transition loads `WAKE_CYCLES`; the others load `CMD_CYCLES`.
    - Any other write sets `err_seq` and leaves the state unchanged.
  - CONFIG: instructions execute normally. Data writes (RS=1) are dropped and set `err_seq`.
  - CONFIG → READY on Display Control with D=1; `init_done`=1 from then on.
  - READY: everything executes.
- **Instruction decode** (RS=0), highest set bit wins:
  - 1aaaaaaa, Set DDRAM: legal addresses are 0x00–0x27 and 0x40–0x67.
    - A legal address loads `cursor_addr`.
    - An illegal address sets `err_addr` and leaves the cursor unchanged.
  - 01xxxxxx, CGRAM address: no-op.
  - 001xNxxx, Function Set: `two_line`=N.
  - 0001xxxx, Shift: no-op.
  - 00001Dxx, Display Control: `disp_on`=D.
  - 000001Ix, Entry Mode: `inc`=I.
  - 0000001x, Return Home: cursor=0x00, busy=`CLR_CYCLES`.
  - 00000001, Clear: all 32 shadow characters=0x20 in one cycle, cursor=0x00, `inc`=1, `upd` pulse, busy=`CLR_CYCLES`.
  - Every instruction except Return Home and Clear loads busy=`CMD_CYCLES`.
- **Data write** (RS=1, READY only)
  - Visible window is cursor 0x00–0x0F or 0x40–0x4F.
  - Inside the window: write shadow[{cursor[6], cursor[3:0]}] and pulse `upd`.
  - Outside the window: the character is discarded.
  - The cursor then steps. Increment wraps 0x27→0x40 and 0x67→0x00; decrement wraps 0x00→0x67 and 0x40→0x27.
  - Busy=`CMD_CYCLES`.
- **Shadow storage**: 32×8 registers, asynchronously reset to 0x20.

## Timing
- **Event latency**
  - Let edge n be the first clock edge that samples `lcd_e`=0 after it was 1.
  - The event executes at edge n+2; its effects on all outputs are visible after edge n+2.
  - `busy_flag` rises at that same edge and stays high for exactly the loaded count of cycles.
- **Read port**: `rd_char` returns shadow[`rd_addr`] one cycle after `rd_addr` is presented. A write and a read to the same index in one cycle return the old value.
- **Reset values**
  - `rd_char`=0x00, `cursor_addr`=0x00, `upd`=0.
  - `disp_on`=0, `two_line`=0, `init_done`=0, `busy_flag`=0.
  - All error flags=0, internal `inc`=1, FSM=RESET, synchronizer stages=0.
- **Reset mid-operation**: asserting `rst_n` low at any cycle, including inside a busy window, forces all of the above immediately. No event is replayed after release.
- **Event width**: an E pulse high for at least 1 sampled cycle produces exactly one event. Pulses narrower than one clock period may be missed.
- **Error flags**: clear only on reset.

## Test plan
- **Driver init sequence**: 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C at the driver's timing (E high 1 cycle, ≥12 cycles between events, 505/15 cycles after the first two wakeups, 202 after Clear).
  - Required: `init_done`=1, `disp_on`=1, `two_line`=1, all errors 0, every `rd_addr` reads 0x20.
- **Positioned write**: after init, write 0xC5 then RS=1 data 0x41.
  - Required: `rd_addr`=21 returns 0x41, `cursor_addr`=0x46, exactly one `upd` pulse.
- **Wrap and window**
  - Set cursor 0x27, write 0x58: no `upd`, `cursor_addr`=0x40.
  - Set cursor 0x4F, write 0x5A: `rd_addr`=31 returns 0x5A, `cursor_addr`=0x50.
  - Entry Mode 0x04 at cursor 0x00, write a character: `cursor_addr`=0x67.
- **Busy violation**: second E fall 2 cycles after the first, with `CMD_CYCLES`=4.
  - Required: `err_busy`=1, second write absent from the shadow.
- **Sequence and address errors**
  - RS=1 write before init: `err_seq`=1, shadow unchanged.
  - After init, command 0xA8: `err_addr`=1, `cursor_addr` unchanged.
- **Reset mid-busy**: drop `rst_n` during a Clear's busy window after characters were written.
  - Required: all outputs at their reset values, shadow all 0x20; a fresh init sequence then completes cleanly.
